// File: rtl/fir_sym_mac.sv
// fir_sym_mac: symmetric FIR filter for unsigned samples using one
// time-multiplexed multiplier. Coefficient memory is writable at run time.
// Each accepted sample produces one rounded, saturated output after M+1
// accumulate/output cycles, where M=(TAPS+1)/2.
//
// Ports:
//   clk        system clock, all state on posedge
//   reset      asynchronous active-high reset, restores default coefficients
//   in_valid   sample offered
//   in_data    unsigned input sample
//   in_ready   block can accept a sample (IDLE and no clear)
//   coef_we    coefficient write strobe
//   coef_addr  coefficient index; c[k] weights taps k and TAPS-1-k
//   coef_data  signed coefficient value
//   coef_err   one-cycle pulse: the previous write was dropped
//   clear      synchronous flush of delay line and abort of computation
//   out_valid  one-cycle pulse, out_data updated
//   out_data   filtered sample, unsigned and saturated; held between outputs
module fir_sym_mac #(
    parameter int DATA_W    = 10,
    parameter int TAPS      = 31,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 14
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    input  logic [DATA_W-1:0]                    in_data,
    output logic                                 in_ready,
    input  logic                                 coef_we,
    input  logic [$clog2((TAPS+1)/2)-1:0]        coef_addr,
    input  logic signed [COEF_W-1:0]             coef_data,
    output logic                                 coef_err,
    input  logic                                 clear,
    output logic                                 out_valid,
    output logic [DATA_W-1:0]                    out_data
);

    localparam int M      = (TAPS + 1) / 2;
    localparam int AW     = $clog2(M);
    localparam int VW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W + 2;
    localparam int ACC_W  = PROD_W + $clog2(M);
    localparam int ROUND  = 1 << (COEF_FRAC - 1);

    localparam logic signed [ACC_W:0]   MAXV     = (ACC_W+1)'((1 << DATA_W) - 1);
    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << COEF_FRAC);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0]        v [TAPS];
    logic signed [COEF_W-1:0] c [M];
    logic signed [ACC_W-1:0]  acc;
    logic [AW-1:0]            idx;

    logic                     accept;
    logic                     coef_ok;
    logic                     last;
    logic [VW-1:0]            lo_i;
    logic [VW-1:0]            hi_i;
    logic [DATA_W:0]          pair;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W:0]    sum_r;
    logic signed [ACC_W:0]    rnd;
    logic [DATA_W-1:0]        sat;

    assign in_ready = (state == IDLE) && !clear;
    assign accept   = in_valid && in_ready;
    assign coef_ok  = coef_we && (state == IDLE) && (32'(coef_addr) < 32'(M));
    assign last     = (idx == AW'(M - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clear overrides every transition
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCUM;
            ACCUM:   if (last)   state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    // One multiply per cycle: symmetric pair sum, or the centre tap alone
    always_comb begin
        lo_i = VW'(idx);
        hi_i = VW'(TAPS - 1) - lo_i;
        if (last) begin
            pair = {1'b0, v[M-1]};
        end else begin
            pair = {1'b0, v[lo_i]} + {1'b0, v[hi_i]};
        end
        prod = c[idx] * $signed({1'b0, pair});
    end

    // Round half up, drop fraction, clamp to the unsigned output range
    always_comb begin
        sum_r = (ACC_W+1)'(acc) + (ACC_W+1)'(ROUND);
        rnd   = sum_r >>> COEF_FRAC;
        if (rnd[ACC_W]) begin
            sat = '0;
        end else if (rnd > MAXV) begin
            sat = '1;
        end else begin
            sat = rnd[DATA_W-1:0];
        end
    end

    // Datapath, coefficient memory and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < TAPS; i++) v[i] <= '0;
            for (int unsigned i = 0; i < M - 1; i++) c[i] <= '0;
            c[M-1]    <= COEF_ONE;
            acc       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            coef_err  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            coef_err  <= coef_we && !coef_ok;
            if (coef_ok) c[coef_addr] <= coef_data;

            if (clear) begin
                for (int unsigned i = 0; i < TAPS; i++) v[i] <= '0;
                acc <= '0;
                idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            v[0] <= in_data;
                            for (int unsigned i = 1; i < TAPS; i++) v[i] <= v[i-1];
                            acc <= '0;
                            idx <= '0;
                        end
                    end
                    ACCUM: begin
                        acc <= acc + ACC_W'(prod);
                        if (!last) idx <= idx + 1'b1;
                    end
                    OUT: begin
                        out_data  <= sat;
                        out_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
